vga_sync_receiver: RTL and testbench
====================================

VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

Interface
REQ-001 Parameter H_BACK, default 160: pixel clocks from hsync deassertion to first visible pixel.
REQ-002 Parameter H_VISIBLE, default 1024: visible pixels per line.
REQ-003 Parameter V_BACK, default 29: lines from vsync deassertion to first visible line.
REQ-004 Parameter V_VISIBLE, default 768: visible lines per frame.
REQ-005 clk  in  1  pixel clock; all inputs synchronous to it.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 hsync, vsync  in  1 each  active-low sync inputs.
REQ-008 red, green, blue  in  8 each  pixel data.
REQ-009 locked  out  1  timing locked.
REQ-010 pixel_valid  out  1  pix_x, pix_y and rgb_o are a visible pixel.
REQ-011 pix_x, pix_y  out  11 each  visible-pixel coordinates.
REQ-012 red_o, green_o, blue_o  out  8 each  captured pixel data.
REQ-013 frame_start  out  1  one-cycle pulse at frame line 0.
REQ-014 h_total, v_total  out  12 each  measured clocks per line and lines per frame.
REQ-015 err  out  1, and err_clr  in  1  sticky lock-loss flag and its clear (see Configuration).

Function
REQ-016 Register all inputs once (stage S1); hs_fall = S1 hsync 0 while the previous S1 hsync was 1.
REQ-017 Position counter hcnt (12 bits) = 0 in the S1 sample where hs_fall occurs, +1 per clock, saturating at 4095.
REQ-018 Measure hsw = number of consecutive S1 samples with hsync low after hs_fall.
REQ-019 On each hs_fall, line length = hcnt + 1 of the ending line.
REQ-020 Sample vsync at hcnt == hsw (first hsync-high sample) once per line.
REQ-021 Line 0 = the first line whose sampled vsync is 0 after a line with sampled vsync 1.
REQ-022 vsw = number of lines with sampled vsync 0.
REQ-023 Line counter vcnt (12 bits) increments per line.
REQ-024 States: SEARCH, MEASURE, LOCKED.
REQ-025 SEARCH -> MEASURE at line 0; record the length of the first line.
REQ-026 MEASURE -> LOCKED at the next line 0 only if all lines of the frame had equal length; load h_total and v_total.
REQ-027 On any mismatch in MEASURE, return to SEARCH.
REQ-028 LOCKED -> SEARCH on any of:
- a line length different from h_total;
- a frame line count different from v_total;
- hcnt saturating (no hs_fall within 4096 clocks).
REQ-029 locked = 1 only in LOCKED, registered from the state.
REQ-030 In LOCKED, a sample is visible when:
- hsw+H_BACK <= hcnt < hsw+H_BACK+H_VISIBLE, and
- vsw+V_BACK <= vcnt < vsw+V_BACK+V_VISIBLE.
REQ-031 For a visible sample, output the following registered: pixel_valid=1, pix_x=hcnt-(hsw+H_BACK), pix_y=vcnt-(vsw+V_BACK), and the rgb data; latency is 2 clocks from input pins.
REQ-032 Outside the visible window: pixel_valid=0 and rgb_o=0; pix_x and pix_y hold their last values.
REQ-033 frame_start pulses for one clock when line 0 is detected, in all states.
REQ-034 Leaving LOCKED drops pixel_valid on the same clock that locked drops.

Reset
REQ-035 While rst is high, all outputs are 0, the state is SEARCH, and all counters and measurements are 0.
REQ-036 Reset asserted mid-frame aborts immediately.
REQ-037 After reset release, lock requires SEARCH->MEASURE->LOCKED again, i.e. at least two line-0 events.

Configuration
REQ-038 Macro VGA_SYNC_RECEIVER_ERR_EN defined: err is set on each LOCKED->SEARCH transition.
REQ-039 err is cleared by err_clr=1; if set and clear coincide, set wins.
REQ-040 Macro not defined: err is tied 0, err_clr is ignored, and there is no err flop.

Verification
REQ-041 Stimulus: ideal source, line of 32 clocks (hsw=4, back 5, visible 20, front 3), frame of 17 lines (vsw=2, back 3, visible 10, front 2), H_BACK=5, H_VISIBLE=20, V_BACK=3, V_VISIBLE=10. Required response: locked=1 after the second line 0; h_total=32; v_total=17; 200 pixel_valid cycles per frame; pix_x 0..19; pix_y 0..9.
REQ-042 Stimulus: pixel data = {x,y,0x5A} under REQ-041 timing. Required response: red_o equals pix_x and green_o equals pix_y on every valid cycle, at 2-clock latency.
REQ-043 Stimulus: while locked, one line of 33 clocks. Required response: locked and pixel_valid drop at that hs_fall; err=1 if the macro is defined; relock after two more frames.
REQ-044 Stimulus: hsync held high for 5000 clocks while locked. Required response: locked=0 by clock 4097; SEARCH state.
REQ-045 Stimulus: rst pulsed mid-frame while locked. Required response: all outputs 0 immediately; frame_start pulses at the next line 0; locked returns one frame later.
REQ-046 Stimulus: err_clr asserted in the same clock as a lock loss, macro defined. Required response: err=1.

Source files
------------

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver
//   Recovers VGA timing from free-running hsync/vsync and pixel data. The
//   block measures the sync widths, line length and frame height, locks once
//   a full frame of identical lines has been seen, and then emits visible
//   pixels with their coordinates. Lock is dropped on any deviation.
//
//   Optional feature: define VGA_SYNC_RECEIVER_ERR_EN to get a sticky err
//   flag set on every loss of lock and cleared by err_clr (set wins).
//   Without the macro err is tied 0 and err_clr is ignored.
//
// Ports
//   clk, rst                    pixel clock, asynchronous active-high reset
//   hsync, vsync                active-low sync inputs
//   red, green, blue            pixel data
//   err_clr                     clear for the sticky err flag
//   locked                      timing locked
//   pixel_valid                 pix_x/pix_y/rgb outputs carry a visible pixel
//   pix_x, pix_y                visible-pixel coordinates
//   red_o, green_o, blue_o      captured pixel data (0 outside the window)
//   frame_start                 one-clock pulse when line 0 is detected
//   h_total, v_total            clocks per line, lines per frame at lock
//   err                         sticky lock-loss flag
module vga_sync_receiver #(
  parameter int H_BACK    = 160,
  parameter int H_VISIBLE = 1024,
  parameter int V_BACK    = 29,
  parameter int V_VISIBLE = 768
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  input  logic        err_clr,
  output logic        locked,
  output logic        pixel_valid,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic [7:0]  red_o,
  output logic [7:0]  green_o,
  output logic [7:0]  blue_o,
  output logic        frame_start,
  output logic [11:0] h_total,
  output logic [11:0] v_total,
  output logic        err
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  localparam logic [11:0] CNT_MAX = 12'hFFF;
  localparam logic [13:0] H_BACK_W = 14'(H_BACK);
  localparam logic [13:0] H_VIS_W  = 14'(H_VISIBLE);
  localparam logic [13:0] V_BACK_W = 14'(V_BACK);
  localparam logic [13:0] V_VIS_W  = 14'(V_VISIBLE);

  state_t      state_q, state_d;

  logic        hs_s1_q, vs_s1_q, hs_prev_q, clr_s1_q;
  logic [7:0]  red_s1_q, green_s1_q, blue_s1_q;

  logic [11:0] hcnt_q, hcnt_d;
  logic [11:0] vcnt_q, vcnt_d;
  logic [11:0] hsw_q, vsw_q;
  logic        hs_in_q, v_in_q, vs_last_q;
  logic [11:0] ref_len_q, ref_len_d;
  logic        have_ref_q, have_ref_d;
  logic [11:0] h_total_q, h_total_d;
  logic [11:0] v_total_q, v_total_d;

  logic        locked_q, pixel_valid_q, frame_start_q;
  logic [10:0] pix_x_q, pix_y_q;
  logic [7:0]  red_q, green_q, blue_q;

  logic        hs_fall, vs_sample, line0, sat;
  logic [11:0] line_len;
  logic [13:0] h_lo, h_hi, v_lo, v_hi;
  logic        h_ok, v_ok, locked_d, vis;

  // ---- Stage S1: input registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_s1_q   <= 1'b0;
      vs_s1_q   <= 1'b0;
      hs_prev_q <= 1'b0;
      clr_s1_q  <= 1'b0;
    end else begin
      hs_s1_q   <= hsync;
      vs_s1_q   <= vsync;
      hs_prev_q <= hs_s1_q;
      clr_s1_q  <= err_clr;
    end
  end

  always_ff @(posedge clk) begin
    red_s1_q   <= red;
    green_s1_q <= green;
    blue_s1_q  <= blue;
  end

  // hcnt_d / vcnt_d are the positions of the sample currently in S1.
  assign hs_fall   = hs_prev_q & ~hs_s1_q;
  assign hcnt_d    = hs_fall ? 12'd0 : ((hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + 12'd1);
  assign sat       = (hcnt_d == CNT_MAX);
  assign line_len  = hcnt_q + 12'd1;
  // First hsync-high sample after a falling edge: hcnt equals hsw here.
  assign vs_sample = hs_in_q & hs_s1_q;
  assign line0     = vs_sample & ~vs_s1_q & vs_last_q;
  assign vcnt_d    = line0 ? 12'd0 :
                     (hs_fall ? ((vcnt_q == CNT_MAX) ? CNT_MAX : vcnt_q + 12'd1) : vcnt_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      hsw_q     <= '0;
      vsw_q     <= '0;
      hs_in_q   <= 1'b0;
      v_in_q    <= 1'b0;
      vs_last_q <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      if (hs_fall) begin
        hs_in_q <= 1'b1;
      end else if (vs_sample) begin
        hs_in_q   <= 1'b0;
        hsw_q     <= hcnt_d;
        vs_last_q <= vs_s1_q;
      end
      // vsw is the index of the first vsync-high line after line 0.
      if (line0) begin
        v_in_q <= 1'b1;
      end else if (vs_sample && vs_s1_q && v_in_q) begin
        v_in_q <= 1'b0;
        vsw_q  <= vcnt_d;
      end
    end
  end

  // ---- Lock state machine ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SEARCH;
      ref_len_q  <= '0;
      have_ref_q <= 1'b0;
      h_total_q  <= '0;
      v_total_q  <= '0;
    end else begin
      state_q    <= state_d;
      ref_len_q  <= ref_len_d;
      have_ref_q <= have_ref_d;
      h_total_q  <= h_total_d;
      v_total_q  <= v_total_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ref_len_d  = ref_len_q;
    have_ref_d = have_ref_q;
    h_total_d  = h_total_q;
    v_total_d  = v_total_q;
    case (state_q)
      SEARCH: begin
        if (line0) begin
          state_d    = MEASURE;
          have_ref_d = 1'b0;
        end
      end
      MEASURE: begin
        if (sat) begin
          state_d = SEARCH;
        end else if (hs_fall) begin
          // The first edge after line 0 ends line 0: its length is the reference.
          if (!have_ref_q) begin
            ref_len_d  = line_len;
            have_ref_d = 1'b1;
          end else if (line_len != ref_len_q) begin
            state_d = SEARCH;
          end
        end else if (line0) begin
          if (have_ref_q) begin
            state_d   = LOCKED;
            h_total_d = ref_len_q;
            v_total_d = vcnt_q;
          end else begin
            state_d = SEARCH;
          end
        end
      end
      LOCKED: begin
        if (sat || (hs_fall && (line_len != h_total_q)) ||
            (line0 && (vcnt_q != v_total_q))) begin
          state_d = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // Visibility uses the next state so pixel_valid falls with locked.
  assign locked_d = (state_d == LOCKED);
  assign h_lo     = {2'b00, hsw_q} + H_BACK_W;
  assign h_hi     = h_lo + H_VIS_W;
  assign v_lo     = {2'b00, vsw_q} + V_BACK_W;
  assign v_hi     = v_lo + V_VIS_W;
  assign h_ok     = ({2'b00, hcnt_d} >= h_lo) && ({2'b00, hcnt_d} < h_hi);
  assign v_ok     = ({2'b00, vcnt_d} >= v_lo) && ({2'b00, vcnt_d} < v_hi);
  assign vis      = locked_d && h_ok && v_ok;

  // ---- Stage S2: output registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked_q      <= 1'b0;
      pixel_valid_q <= 1'b0;
      frame_start_q <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
    end else begin
      locked_q      <= locked_d;
      pixel_valid_q <= vis;
      frame_start_q <= line0;
      if (vis) begin
        pix_x_q <= hcnt_d[10:0] - h_lo[10:0];
        pix_y_q <= vcnt_d[10:0] - v_lo[10:0];
        red_q   <= red_s1_q;
        green_q <= green_s1_q;
        blue_q  <= blue_s1_q;
      end else begin
        red_q   <= '0;
        green_q <= '0;
        blue_q  <= '0;
      end
    end
  end

  assign locked      = locked_q;
  assign pixel_valid = pixel_valid_q;
  assign frame_start = frame_start_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign red_o       = red_q;
  assign green_o     = green_q;
  assign blue_o      = blue_q;
  assign h_total     = h_total_q;
  assign v_total     = v_total_q;

`ifdef VGA_SYNC_RECEIVER_ERR_EN
  logic err_q;

  // Set on LOCKED->SEARCH; set takes priority over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((state_q == LOCKED) && (state_d == SEARCH)) begin
      err_q <= 1'b1;
    end else if (clr_s1_q) begin
      err_q <= 1'b0;
    end
  end

  assign err = err_q;
`else
  logic unused_clr;

  assign unused_clr = clr_s1_q;
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
module tb_vga_sync_receiver;

  localparam int HB = 5, HV = 20, VB = 3, VV = 10;
  localparam int HSW = 4, VSW = 2, LINE = 32, FRAME = 17;

`ifdef VGA_SYNC_RECEIVER_ERR_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsync = 1'b1, vsync = 1'b1, err_clr = 1'b0;
  logic [7:0]  red = '0, green = '0, blue = '0;
  logic        locked, pixel_valid, frame_start, err;
  logic [10:0] pix_x, pix_y;
  logic [7:0]  red_o, green_o, blue_o;
  logic [11:0] h_total, v_total;

  vga_sync_receiver #(
    .H_BACK(HB), .H_VISIBLE(HV), .V_BACK(VB), .V_VISIBLE(VV)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue), .err_clr(err_clr),
    .locked(locked), .pixel_valid(pixel_valid), .pix_x(pix_x), .pix_y(pix_y),
    .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
    .frame_start(frame_start), .h_total(h_total), .v_total(v_total), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit chk;
    bit lk;
    bit vis;
    bit fs;
    int x;
    int y;
  } exp_t;

  typedef struct {
    int mode;
    int bad;
    int clr_v;
    int lk;
    int nvalid;
    int nfs;
    int ht;
    int vt;
    int err;
  } frm_t;

  exp_t sbq[$];
  int   n_chk = 0, n_fail = 0;
  int   vcount = 0, fscount = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_zero(input string name);
    n_chk++;
    if ({locked, pixel_valid, frame_start, err, pix_x, pix_y, red_o, green_o,
         blue_o, h_total, v_total} !== '0) begin
      n_fail++;
      $display("FAIL %s: outputs lk=%b pv=%b fs=%b err=%b x=%0d y=%0d rgb=%h%h%h ht=%0d vt=%0d, expected all 0",
               name, locked, pixel_valid, frame_start, err, pix_x, pix_y,
               red_o, green_o, blue_o, h_total, v_total);
    end
  endtask

  // One clock: compare the output produced by the pins driven two clocks ago,
  // then drive the next pin sample and queue its expected result.
  task automatic step(input bit hs, input bit vs, input int r, input int g,
                      input int b, input bit clr, input exp_t e);
    exp_t o;
    @(negedge clk);
    if (sbq.size() >= 2) begin
      o = sbq.pop_front();
      if (o.chk) begin
        n_chk++;
        if (locked !== o.lk || pixel_valid !== o.vis || frame_start !== o.fs ||
            (o.vis && (pix_x !== 11'(o.x) || pix_y !== 11'(o.y) ||
                       red_o !== 8'(o.x) || green_o !== 8'(o.y) || blue_o !== 8'h5A)) ||
            (!o.vis && {red_o, green_o, blue_o} !== 24'h0)) begin
          n_fail++;
          $display("FAIL pixel @%0t: lk=%b pv=%b fs=%b x=%0d y=%0d rgb=%h%h%h, expected lk=%b pv=%b fs=%b x=%0d y=%0d",
                   $time, locked, pixel_valid, frame_start, pix_x, pix_y,
                   red_o, green_o, blue_o, o.lk, o.vis, o.fs, o.x, o.y);
        end
      end
    end
    if (pixel_valid === 1'b1) vcount++;
    if (frame_start === 1'b1) fscount++;
    hsync   = hs;
    vsync   = vs;
    red     = 8'(r);
    green   = 8'(g);
    blue    = 8'(b);
    err_clr = clr;
    sbq.push_back(e);
  endtask

  // Drive samples h0..h1-1 of source line v; locked expected from sample lk_from.
  task automatic drive_line(input int v, input int h0, input int h1,
                            input int lk_from, input bit chk, input int clr_h);
    for (int h = h0; h < h1; h++) begin
      bit   geo;
      exp_t e;
      geo   = (h >= HSW + HB) && (h < HSW + HB + HV) &&
              (v >= VSW + VB) && (v < VSW + VB + VV);
      e.chk = chk;
      e.lk  = (h >= lk_from);
      e.vis = e.lk && geo;
      e.fs  = (v == 0) && (h == HSW);
      e.x   = h - (HSW + HB);
      e.y   = v - (VSW + VB);
      step(h >= HSW, v >= VSW, geo ? e.x : 255, geo ? e.y : 255,
           geo ? 8'h5A : 255, h == clr_h, e);
    end
  endtask

  // mode 0: never locked; 1: locks at line 0; 2: locked throughout;
  // 3: locked until line 'bad' (33 clocks) ends.
  task automatic run_frame(input int mode, input int bad, input int clr_v);
    for (int v = 0; v < FRAME; v++) begin
      int lf;
      case (mode)
        0:       lf = 99;
        1:       lf = (v == 0) ? HSW : 0;
        2:       lf = 0;
        default: lf = (v > bad) ? 99 : 0;
      endcase
      drive_line(v, 0, (v == bad) ? LINE + 1 : LINE, lf, 1'b1, (v == clr_v) ? 0 : -1);
    end
  endtask

  initial begin
    frm_t tbl[7];
    tbl[0] = '{0, -1, -1, 0,   0, 1,  0,  0, 0};
    tbl[1] = '{1, -1, -1, 1, 200, 1, 32, 17, 0};
    tbl[2] = '{2, -1, -1, 1, 200, 1, 32, 17, 0};
    tbl[3] = '{3,  8,  9, 0,  80, 1, 32, 17, ERR_EN};
    tbl[4] = '{0, -1, -1, 0,   0, 1, 32, 17, ERR_EN};
    tbl[5] = '{1, -1, -1, 1, 200, 1, 32, 17, ERR_EN};
    tbl[6] = '{2, -1, -1, 1, 200, 1, 32, 17, ERR_EN};

    repeat (2) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;

    // Idle, then the tail of a frame so that line 0 follows vsync-high lines.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 255, 255, 255, 1'b0, '{1, 0, 0, 0, 0, 0});
    for (int v = 14; v < FRAME; v++) drive_line(v, 0, LINE, 99, 1'b1, -1);

    for (int i = 0; i < 7; i++) begin
      vcount  = 0;
      fscount = 0;
      run_frame(tbl[i].mode, tbl[i].bad, tbl[i].clr_v);
      check($sformatf("frame%0d_locked", i), int'(locked), tbl[i].lk);
      check($sformatf("frame%0d_valid_count", i), vcount, tbl[i].nvalid);
      check($sformatf("frame%0d_frame_start_count", i), fscount, tbl[i].nfs);
      check($sformatf("frame%0d_h_total", i), int'(h_total), tbl[i].ht);
      check($sformatf("frame%0d_v_total", i), int'(v_total), tbl[i].vt);
      check($sformatf("frame%0d_err", i), int'(err), tbl[i].err);
    end

    // hsync stuck high: lock lost on the 4096th clock after the last edge.
    for (int k = 0; k < 5000; k++) begin
      exp_t e;
      e = '{1, (LINE + k < 4095), 0, 0, 0, 0};
      step(1'b1, 1'b1, 255, 255, 255, k == 10, e);
      if (k == 20) check("err_cleared", int'(err), 0);
    end
    check("hold_locked", int'(locked), 0);
    check("hold_err", int'(err), ERR_EN);

    // Re-acquire.
    for (int v = 14; v < FRAME; v++) drive_line(v, 0, LINE, 99, 1'b1, -1);
    run_frame(0, -1, -1);
    vcount = 0;
    run_frame(1, -1, -1);
    check("relock_locked", int'(locked), 1);
    check("relock_valid_count", vcount, 200);

    // Reset in the middle of a locked frame.
    for (int v = 0; v < 8; v++) drive_line(v, 0, LINE, 0, 1'b1, -1);
    drive_line(8, 0, 16, 0, 1'b1, -1);
    rst = 1'b1;
    #1;
    check_zero("reset_mid_frame");
    sbq.delete();
    drive_line(8, 16, 19, 99, 1'b0, -1);
    rst = 1'b0;
    drive_line(8, 19, LINE, 99, 1'b0, -1);
    for (int v = 9; v < FRAME; v++) drive_line(v, 0, LINE, 99, 1'b1, -1);
    fscount = 0;
    run_frame(0, -1, -1);
    check("post_reset_frame_start", fscount, 1);
    check("post_reset_not_locked", int'(locked), 0);
    vcount = 0;
    run_frame(1, -1, -1);
    check("post_reset_locked", int'(locked), 1);
    check("post_reset_valid_count", vcount, 200);
    check("post_reset_h_total", int'(h_total), 32);
    check("post_reset_v_total", int'(v_total), 17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
